// File: rtl/sync_fifo_param.sv
// Single-clock DEPTH x WIDTH FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; the default build registers data_out on pop.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             pop_ok;
  logic             push_ok;

  // A push into a full FIFO is still accepted when a pop frees the head slot on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: default first so every path assigns count_next; otherwise a latch is inferred.
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      // Flags come from the next count so they move on the same edge as count itself.
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      if (push && !push_ok) overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (pop && !pop_ok)   underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; entries past the pointers are simply treated as discarded.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (rst)         data_out <= '0;
    else if (pop_ok) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model compared every cycle,
// plus directed literal checks. Works with or without SYNC_FIFO_FWFT_EN defined.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             pop = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;
  bit               chk_en = 1'b0;
  int               total_push = 0;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: FIFO semantics expressed directly on a queue.
  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else begin
      pop_ok  = pop && (q.size() > 0);
      push_ok = push && ((q.size() < DEPTH) || pop_ok);
      if (push && !push_ok) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (pop && !pop_ok)   m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) begin
        q.push_back(data_in);
        total_push++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count",        32'(count),        32'(q.size()));
      check("empty",        32'(empty),        32'(q.size() == 0));
      check("full",         32'(full),         32'(q.size() == DEPTH));
      check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
      if (q.size() > 0) check("data_out_head", 32'(data_out), 32'(q[0]));
`else
      check("data_out", 32'(data_out), 32'(m_dout));
`endif
    end
  end

  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic o,
                      input logic c = 1'b0, input logic r = 1'b0);
    push = p; data_in = d; pop = o; err_clr = c; rst = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1 Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ae",    32'(almost_empty), 1);
    check("rst_af",    32'(almost_full), 0);
    check("rst_ovf",   32'(overflow), 0);

    // 2 Fill
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0);
      if (i == 1) check("ae_at_2", 32'(almost_empty), 1);
      if (i == 2) check("ae_drop_at_3", 32'(almost_empty), 0);
      if (i == 12) check("af_at_13", 32'(almost_full), 0);
      if (i == 13) check("af_at_14", 32'(almost_full), 1);
      if (i == 14) check("full_at_15", 32'(full), 0);
    end
    check("full_at_16", 32'(full), 1);
    step(1, 8'hAA, 0);
    check("ovf_17th", 32'(overflow), 1);
    check("count_17th", 32'(count), 16);

    // 3 Drain
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft_head", 32'(data_out), 32'(i));
      step(0, 0, 1);
`else
      step(0, 0, 1);
      check("std_dout", 32'(data_out), 32'(i));
`endif
    end
    step(0, 0, 1);
    check("udf_17th", 32'(underflow), 1);
    check("count_0", 32'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("dout_hold", 32'(data_out), 32'h0F);
`endif
    step(0, 0, 0, 1);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_udf", 32'(underflow), 0);

    // 4 Simultaneous push+pop at full and empty
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0);
    step(1, 8'h77, 1);
    check("full_pp_count", 32'(count), 16);
    check("full_pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
    step(1, 8'h55, 1);
    check("empty_pp_count", 32'(count), 1);
    check("empty_pp_udf", 32'(underflow), 1);
    step(0, 0, 0, 1);
    check("clr_udf2", 32'(underflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) step(1, 8'(8'h40 + i), 0);
    step(1, 8'hEE, 0, 1);
    check("set_wins_ovf", 32'(overflow), 1);
    step(0, 0, 0, 1);
    check("clr_ovf2", 32'(overflow), 0);
    while (q.size() > 8) step(0, 0, 1);

    // 5 Wrap: random interleaving keeping occupancy within 5..12
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if (q.size() <= 5)       step(1, 8'($urandom), (r == 3));
      else if (q.size() >= 12) step((r == 3), 8'($urandom), 1);
      else                     step((r != 1), 8'($urandom), (r != 0));
    end
    check("wrap_pushes", 32'(total_push >= 2 * DEPTH), 1);

    // 6 Mid-op reset
    while (q.size() > 7) step(0, 0, 1);
    while (q.size() < 7) step(1, 8'h99, 0);
    check("pre_rst_count", 32'(count), 7);
    step(1, 8'hC3, 1, 0, 1);
    check("midrst_count", 32'(count), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_dout_or_empty", 32'(empty), 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("midrst_dout", 32'(data_out), 0);
`endif
    step(1, 8'h33, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_33", 32'(data_out), 32'h33);
`endif
    step(0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("std_33", 32'(data_out), 32'h33);
`endif
    check("final_empty", 32'(empty), 1);
    step(0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
